// File: rtl/reg_file_wb.sv
// Write-back register file: two combinational read ports with WB->ID bypass,
// plus a per-register pending-write scoreboard that drives the ID stall flags.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] regWriteData,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueReg,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              busy1,
    output logic              busy2,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [DATA_W-1:0] regs_r    [DEPTH];
    logic [CNT_W-1:0]  cnt_r     [DEPTH];
    logic [CNT_W-1:0]  cnt_nxt_s [DEPTH];
    logic [DEPTH-1:0]  inc_s;
    logic [DEPTH-1:0]  dec_s;
    logic              overflow_r;
    logic              ovf_hit_s;
    logic              wr_en_s;
    logic              issue_en_s;

    // Index 0 is hardwired, so neither writes nor issues to it have any effect.
    assign wr_en_s    = RegWrite && (writeReg != ADDR_ZERO);
    assign issue_en_s = issueValid && (issueReg != ADDR_ZERO);

    // Scoreboard next state: an issue and a retire on the same register cancel out.
    always_comb begin
        ovf_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            inc_s[i]     = issue_en_s && (issueReg == ADDR_W'(i));
            dec_s[i]     = wr_en_s && (writeReg == ADDR_W'(i));
            cnt_nxt_s[i] = cnt_r[i];
            case ({inc_s[i], dec_s[i]})
                2'b10: begin
                    if (cnt_r[i] == CNT_MAX) begin
                        cnt_nxt_s[i] = cnt_r[i];
                        ovf_hit_s    = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (cnt_r[i] == CNT_ZERO) begin
                        cnt_nxt_s[i] = CNT_ZERO;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
                    end
                end
                default: cnt_nxt_s[i] = cnt_r[i];
            endcase
        end
    end

    // State update: register array, pending counters and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= DATA_ZERO;
                cnt_r[i]  <= CNT_ZERO;
            end
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                regs_r[writeReg] <= regWriteData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            overflow_r <= overflow_r | ovf_hit_s;
        end
    end

    // Read ports: zero index, then same-cycle bypass, then array contents.
    always_comb begin
        readData1 = regs_r[readReg1];
        readData2 = regs_r[readReg2];
        if (readReg1 == ADDR_ZERO) begin
            readData1 = DATA_ZERO;
        end else if (wr_en_s && (writeReg == readReg1)) begin
            readData1 = regWriteData;
        end else begin
            readData1 = regs_r[readReg1];
        end
        if (readReg2 == ADDR_ZERO) begin
            readData2 = DATA_ZERO;
        end else if (wr_en_s && (writeReg == readReg2)) begin
            readData2 = regWriteData;
        end else begin
            readData2 = regs_r[readReg2];
        end
    end

    // Stall flags: the last outstanding write retiring this cycle is covered by the bypass.
    always_comb begin
        busy1 = (cnt_r[readReg1] != CNT_ZERO) &&
                !(wr_en_s && (writeReg == readReg1) && (cnt_r[readReg1] == CNT_ONE));
        busy2 = (cnt_r[readReg2] != CNT_ZERO) &&
                !(wr_en_s && (writeReg == readReg2) && (cnt_r[readReg2] == CNT_ONE));
    end

    assign overflow = overflow_r;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: directed per-cycle vectors push expectations into a
// queue; a negedge monitor pops each one and compares it with the DUT outputs.
module tb_reg_file_wb;

    logic        clock;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] regWriteData;
    logic        issueValid;
    logic [4:0]  issueReg;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        busy1;
    logic        busy2;
    logic        overflow;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        b1;
        logic        b2;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .RegWrite(RegWrite), .writeReg(writeReg),
        .regWriteData(regWriteData), .issueValid(issueValid), .issueReg(issueReg),
        .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1),
        .readData2(readData2), .busy1(busy1), .busy2(busy2), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: the outputs are combinational, so each cycle's vector is checked mid-cycle.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, "readData1", readData1, e.e1);
            check(e.name, "readData2", readData2, e.e2);
            check(e.name, "busy1", {31'd0, busy1}, {31'd0, e.b1});
            check(e.name, "busy2", {31'd0, busy2}, {31'd0, e.b2});
            check(e.name, "overflow", {31'd0, overflow}, {31'd0, e.ov});
        end
    end

    task automatic cyc(input string name, input logic rs,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ir,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic b1, input logic b2, input logic ov);
        exp_t e;
        @(posedge clock);
        #1;
        reset        = rs;
        RegWrite     = we;
        writeReg     = wr;
        regWriteData = wd;
        issueValid   = iv;
        issueReg     = ir;
        readReg1     = r1;
        readReg2     = r2;
        e.name = name; e.e1 = e1; e.e2 = e2; e.b1 = b1; e.b2 = b2; e.ov = ov;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; RegWrite = 1'b0; writeReg = 5'd0; regWriteData = 32'd0;
        issueValid = 1'b0; issueReg = 5'd0; readReg1 = 5'd0; readReg2 = 5'd0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 32; i++) begin
            cyc("reset_read", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                5'(i), 5'(31 - i), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        end

        //   name         rs    we    wr     wd             iv    ir     r1     r2     e1             e2             b1    b2    ov
        cyc("bypass5",   1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'd0,         1'b0, 1'b0, 1'b0);
        cyc("hold5",     1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        cyc("bypass12",  1'b0, 1'b1, 5'd12, 32'hA5A5A5A5, 1'b0, 5'd0,  5'd5,  5'd12, 32'hDEADBEEF, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        cyc("write0",    1'b0, 1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  5'd0,  5'd0,  32'd0,         32'd0,         1'b0, 1'b0, 1'b0);
        cyc("read0",     1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd0,  5'd12, 32'd0,         32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        cyc("issue8",    1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd8,  5'd0,  5'd8,  32'd0,         32'd0,         1'b0, 1'b0, 1'b0);
        cyc("busy8",     1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd0,  5'd8,  32'd0,         32'd0,         1'b0, 1'b1, 1'b0);
        cyc("retire8",   1'b0, 1'b1, 5'd8,  32'h42,        1'b0, 5'd0,  5'd0,  5'd8,  32'd0,         32'h42,        1'b0, 1'b0, 1'b0);
        cyc("post8",     1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd8,  5'd8,  32'h42,        32'h42,        1'b0, 1'b0, 1'b0);
        // Saturate the counter of register 3 and overflow it.
        cyc("iss3_a",    1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd3,  5'd3,  5'd0,  32'd0,         32'd0,         1'b0, 1'b0, 1'b0);
        cyc("iss3_b",    1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd3,  5'd3,  5'd0,  32'd0,         32'd0,         1'b1, 1'b0, 1'b0);
        cyc("iss3_c",    1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd3,  5'd3,  5'd0,  32'd0,         32'd0,         1'b1, 1'b0, 1'b0);
        cyc("iss3_d",    1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd3,  5'd3,  5'd0,  32'd0,         32'd0,         1'b1, 1'b0, 1'b0);
        cyc("ovf_set",   1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd3,  5'd0,  32'd0,         32'd0,         1'b1, 1'b0, 1'b1);
        cyc("iss_wr3",   1'b0, 1'b1, 5'd3,  32'h33,        1'b1, 5'd3,  5'd3,  5'd0,  32'h33,        32'd0,         1'b1, 1'b0, 1'b1);
        // Drain: counter must still be 3, so only the third retire clears busy.
        cyc("drain3_a",  1'b0, 1'b1, 5'd3,  32'h34,        1'b0, 5'd0,  5'd3,  5'd0,  32'h34,        32'd0,         1'b1, 1'b0, 1'b1);
        cyc("drain3_b",  1'b0, 1'b1, 5'd3,  32'h35,        1'b0, 5'd0,  5'd3,  5'd0,  32'h35,        32'd0,         1'b1, 1'b0, 1'b1);
        cyc("drain3_c",  1'b0, 1'b1, 5'd3,  32'h36,        1'b0, 5'd0,  5'd3,  5'd0,  32'h36,        32'd0,         1'b0, 1'b0, 1'b1);
        cyc("idle3",     1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd3,  5'd3,  32'h36,        32'h36,        1'b0, 1'b0, 1'b1);
        cyc("under3",    1'b0, 1'b1, 5'd3,  32'h37,        1'b0, 5'd0,  5'd3,  5'd0,  32'h37,        32'd0,         1'b0, 1'b0, 1'b1);
        cyc("post_und3", 1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd3,  5'd0,  32'h37,        32'd0,         1'b0, 1'b0, 1'b1);
        // Reset in the middle of traffic on register 9.
        cyc("wr9",       1'b0, 1'b1, 5'd9,  32'h55,        1'b0, 5'd0,  5'd9,  5'd0,  32'h55,        32'd0,         1'b0, 1'b0, 1'b1);
        cyc("iss9",      1'b0, 1'b0, 5'd0,  32'd0,         1'b1, 5'd9,  5'd9,  5'd0,  32'h55,        32'd0,         1'b0, 1'b0, 1'b1);
        cyc("busy9",     1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd9,  5'd0,  32'h55,        32'd0,         1'b1, 1'b0, 1'b1);
        cyc("rst_wr9",   1'b1, 1'b1, 5'd9,  32'h77,        1'b1, 5'd9,  5'd9,  5'd0,  32'h77,        32'd0,         1'b0, 1'b0, 1'b1);
        cyc("after_rst", 1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd9,  5'd3,  32'd0,         32'd0,         1'b0, 1'b0, 1'b0);
        cyc("after_rst2",1'b0, 1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  5'd5,  5'd8,  32'd0,         32'd0,         1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        check("drain", "queue_left", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
